rf_wb_sched: RTL
================

Name: rf_wb_sched

Overview:
- Write-port scheduler and scoreboard for the 32x32 register file.
- The register file has one write port, written on negedge clk. Two writeback sources share it:
  - the in-order pipeline WB stage;
  - a long-latency unit (LSU miss path / iterative divider) with valid/ready handshake.
- Tracks destinations with outstanding long-latency writes. Raises decode-stage hazard stalls for RAW/WAW on those registers.
- Sits between the WB stage, the long unit, the decode hazard logic and the register-file write port.

Parameters:
- STARVE_MAX, 3: max consecutive cycles a long-unit request waits before it is granted priority over the pipeline.
- MAX_OUT, 4: max outstanding long-latency ops; extra issues are stalled.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- p_wb_valid  in  1  pipeline WB wants to write.
- p_wb_rd  in  5  pipeline destination.
- p_wb_data  in  32  pipeline write data.
- p_wb_stall  out  1  pipeline WB must hold (write not taken this cycle).
- l_wb_valid  in  1  long unit result valid.
- l_wb_rd  in  5  long unit destination.
- l_wb_data  in  32  long unit data.
- l_wb_ready  out  1  long unit result accepted this cycle.
- iss_valid  in  1  decode issuing a long-latency op this cycle.
- iss_rd  in  5  destination of that op.
- dec_rs1  in  5  decode source 1.
- dec_rs2  in  5  decode source 2.
- dec_rd  in  5  decode destination.
- hz_stall  out  1  decode must stall.
- rf_wr_en  out  1  to register-file write enable.
- rf_rd_addr  out  5  to register-file write address.
- rf_rd_data  out  32  to register-file write data.

Behaviour:
- State:
  - busy[31:1] scoreboard; busy[0] hardwired 0.
  - out_cnt, 0..MAX_OUT.
  - starve_cnt, 0..STARVE_MAX.
  - FSM state {P_PRIO, L_PRIO}.
- Reset: busy=0, out_cnt=0, starve_cnt=0, state=P_PRIO. Outputs are combinational from state.
- Reset mid-operation: all pending scoreboard entries are discarded; the pipeline flushes externally.
- Grant (combinational, 0-cycle latency; the write lands at the same cycle's negedge):
  - P_PRIO: p_wb_valid wins.
    - l_wb_ready = l_wb_valid & !p_wb_valid.
    - p_wb_stall = 0.
  - L_PRIO: l_wb_valid wins.
    - p_wb_stall = p_wb_valid & l_wb_valid.
    - l_wb_ready = l_wb_valid.
- rf_wr_en: asserted for the granted source only when its rd != 0. rf_rd_addr and rf_rd_data are muxed from the winner. When there is no grant: rf_wr_en=0, addr/data=0.
- Handshake: the long unit holds l_wb_valid, rd and data stable until l_wb_ready. The pipeline holds its WB inputs while p_wb_stall.
- Starvation counter:
  - Increments when l_wb_valid & !l_wb_ready, saturating at STARVE_MAX.
  - Clears on any l_wb accept.
- FSM transitions:
  - P_PRIO -> L_PRIO when starve_cnt == STARVE_MAX & l_wb_valid.
  - L_PRIO -> P_PRIO after one l_wb accept, or if l_wb_valid drops.
- Scoreboard, with iss_fire = iss_valid & !hz_stall:
  - Set: iss_fire & iss_rd != 0 sets busy[iss_rd].
  - Clear: l_wb accept clears busy[l_wb_rd].
  - Same rd set and cleared in the same cycle: set wins (new producer).
- out_cnt:
  - +1 on iss_fire (including rd=0).
  - -1 on l_wb accept.
  - Both in the same cycle: unchanged.
  - l_wb accept with out_cnt==0: ignored, never underflows.
- hz_stall is asserted when any of:
  - busy[dec_rs1];
  - busy[dec_rs2];
  - busy[dec_rd] (WAW);
  - iss_valid & out_cnt==MAX_OUT.
- Register 0 is never busy and never written.

Optional Feature:
- RF_SB_BYPASS_EN
  - Defined: in the cycle an l_wb accept clears busy[r], decode reads of r are not stalled on that register, since the negedge write makes the data readable combinationally in time. hz_stall masks that term.
  - Undefined: the stall is taken until the cycle after the clear.

Decomposition:
- Package rf_sched_pkg:
  - REG_AW=5, REG_DW=32, NUM_REGS=32;
  - typedef sched_state_e {P_PRIO, L_PRIO};
  - typedef reg_addr_t.
- Sub-module rf_scoreboard: busy bits, out_cnt and hazard compare. The top keeps the arbiter FSM, starvation counter and write mux.

Test Plan:
- Reset mid-run: after issuing to x5, pull rst_n low async -> busy=0, out_cnt=0, hz_stall=0, rf_wr_en=0 immediately.
- Contention: l_wb_valid held with rd=7 and p_wb_valid every cycle, STARVE_MAX=3 ->
  - pipeline granted 3 cycles;
  - 4th cycle: l_wb_ready=1, p_wb_stall=1, rf_rd_addr=7.
  - Next cycle: back to P_PRIO.
- RAW: issue to x10, then decode dec_rs1=10 -> hz_stall=1 until the long write of x10 accepts.
  - Stall drops the next cycle (same cycle with RF_SB_BYPASS_EN).
- x0: pipeline WB rd=0 data=0xDEADBEEF -> rf_wr_en=0. Issue with iss_rd=0 -> no busy bit, out_cnt increments.
- Capacity: MAX_OUT=4, four issues to x1..x4 then iss_valid -> hz_stall=1. One l_wb accept, with iss_valid still held -> the stall releases the same cycle, and the new issue fires that cycle.
- Same-cycle set/clear: l_wb accept for x9 while issuing to x9 -> busy[9] stays 1, out_cnt unchanged.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// ---------------------------------------------------------------------------
// rf_sched_pkg
// Shared types and sizes for the register-file write-port scheduler.
//   REG_AW / REG_DW / NUM_REGS : register-file geometry (32 x 32-bit)
//   reg_addr_t / reg_data_t    : register index and data word
//   sched_state_e              : write-port arbiter priority state
// ---------------------------------------------------------------------------
package rf_sched_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    typedef enum logic {
        P_PRIO = 1'b0,   // pipeline WB owns the write port
        L_PRIO = 1'b1    // starved long-unit result owns the write port
    } sched_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Busy bits for destinations of outstanding long-latency ops, the
// outstanding-op counter and the decode hazard compare.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   iss_valid, iss_rd decode issuing a long-latency op and its destination
//   l_acc, l_rd       long-unit writeback accepted this cycle and its dest
//   dec_rs1/rs2/rd    decode-stage operands to check
//   hz_stall          decode must stall
//
// Optional macro RF_SB_BYPASS_EN: a source read of the register being
// written back this cycle is not stalled (the negedge write makes it
// readable in time). Without it the stall lasts until the cycle after.
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_sched_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      iss_valid,
    input  reg_addr_t iss_rd,
    input  logic      l_acc,
    input  reg_addr_t l_rd,
    input  reg_addr_t dec_rs1,
    input  reg_addr_t dec_rs2,
    input  reg_addr_t dec_rd,
    output logic      hz_stall
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic                rs1_hz, rs2_hz, rd_hz, full_hz;
    logic                iss_fire, dec_ok;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rs1_hz = busy_q[dec_rs1];
        rs2_hz = busy_q[dec_rs2];
        rd_hz  = busy_q[dec_rd];
`ifdef RF_SB_BYPASS_EN
        if (l_acc && (l_rd == dec_rs1)) rs1_hz = 1'b0;
        if (l_acc && (l_rd == dec_rs2)) rs2_hz = 1'b0;
`endif
        // A writeback retiring this cycle frees a slot for an issue in the
        // same cycle, so the capacity stall releases without a bubble.
        full_hz  = iss_valid && (out_cnt_q == CNT_W'(MAX_OUT)) && !l_acc;
        hz_stall = rs1_hz || rs2_hz || rd_hz || full_hz;
        iss_fire = iss_valid && !hz_stall;

        // A stray accept with nothing outstanding must not underflow.
        dec_ok = l_acc && (out_cnt_q != '0);

        busy_d = busy_q;
        if (l_acc) busy_d[l_rd] = 1'b0;
        // Set after clear: a new producer for the same register wins.
        if (iss_fire) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;

        out_cnt_d = out_cnt_q;
        unique case ({iss_fire, dec_ok})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            out_cnt_q <= '0;
        end else begin
            busy_q    <= busy_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// ---------------------------------------------------------------------------
// rf_wb_sched
// Write-port scheduler and scoreboard for the 32x32 register file. The
// pipeline WB stage and a long-latency unit share the single write port
// (written on negedge clk); a starvation counter hands priority to the
// long unit for one accept. Decode hazards on outstanding long-latency
// destinations come from rf_scoreboard.
//
// Ports:
//   clk, rst_n                         clock / async active-low reset
//   p_wb_valid/rd/data, p_wb_stall     pipeline WB request and hold
//   l_wb_valid/rd/data, l_wb_ready     long-unit result handshake
//   iss_valid, iss_rd                  long-latency issue from decode
//   dec_rs1, dec_rs2, dec_rd, hz_stall decode hazard check
//   rf_wr_en, rf_rd_addr, rf_rd_data   register-file write port
//
// Optional macro RF_SB_BYPASS_EN (see rf_scoreboard).
// ---------------------------------------------------------------------------
module rf_wb_sched
    import rf_sched_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int MAX_OUT    = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      p_wb_valid,
    input  reg_addr_t p_wb_rd,
    input  reg_data_t p_wb_data,
    output logic      p_wb_stall,
    input  logic      l_wb_valid,
    input  reg_addr_t l_wb_rd,
    input  reg_data_t l_wb_data,
    output logic      l_wb_ready,
    input  logic      iss_valid,
    input  reg_addr_t iss_rd,
    input  reg_addr_t dec_rs1,
    input  reg_addr_t dec_rs2,
    input  reg_addr_t dec_rd,
    output logic      hz_stall,
    output logic      rf_wr_en,
    output reg_addr_t rf_rd_addr,
    output reg_data_t rf_rd_data
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    sched_state_e    state_q, state_d;
    logic [SC_W-1:0] starve_q, starve_d;
    logic            p_grant, l_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= P_PRIO;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        p_grant    = 1'b0;
        l_grant    = 1'b0;
        rf_wr_en   = 1'b0;
        rf_rd_addr = '0;
        rf_rd_data = '0;
        starve_d   = starve_q;
        state_d    = state_q;

        unique case (state_q)
            P_PRIO: begin
                p_grant = p_wb_valid;
                l_grant = l_wb_valid && !p_wb_valid;
            end
            L_PRIO: begin
                l_grant = l_wb_valid;
                p_grant = p_wb_valid && !l_wb_valid;
            end
            default: ;
        endcase

        // No write-port activity while reset is held; pending work is
        // discarded and the pipeline flushes on its own.
        if (!rst_n) begin
            p_grant = 1'b0;
            l_grant = 1'b0;
        end

        p_wb_stall = p_wb_valid && !p_grant;
        l_wb_ready = l_grant;

        if (p_grant) begin
            rf_wr_en   = (p_wb_rd != '0);
            rf_rd_addr = p_wb_rd;
            rf_rd_data = p_wb_data;
        end else if (l_grant) begin
            rf_wr_en   = (l_wb_rd != '0);
            rf_rd_addr = l_wb_rd;
            rf_rd_data = l_wb_data;
        end

        if (l_grant)
            starve_d = '0;
        else if (l_wb_valid && (starve_q != SC_W'(STARVE_MAX)))
            starve_d = starve_q + SC_W'(1);

        // Switching on the updated count gives the long unit the port on
        // the cycle right after its STARVE_MAX-th lost cycle.
        unique case (state_q)
            P_PRIO: if (l_wb_valid && (starve_d == SC_W'(STARVE_MAX))) state_d = L_PRIO;
            L_PRIO: if (l_grant || !l_wb_valid) state_d = P_PRIO;
            default: state_d = P_PRIO;
        endcase
    end

    rf_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .l_acc     (l_grant),
        .l_rd      (l_wb_rd),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .dec_rd    (dec_rd),
        .hz_stall  (hz_stall)
    );

endmodule
